seq_mult: RTL

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_mult.sv
// seq_mult -- iterative shift-add multiplier.
//
// Computes the low N bits of a*b using one add/shift step per clock over N
// clocks. This is correct for unsigned and two's-complement operands alike,
// and overflow is not reported.
//
// Parameters:
//   N       operand and result width in bits (N >= 2)
//
// Ports:
//   clk     single clock; all state updates on the rising edge
//   reset   synchronous, active-high reset
//   start   request pulse; a and b are captured in the same cycle (IDLE only)
//   a, b    multiplicand / multiplier
//   busy    high while the state is RUN or DONE
//   done    one-cycle pulse while the state is DONE; result is valid
//   result  low N bits of a*b, held until the next completion
//   zero    high when the registered result is zero
module seq_mult #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [N-1:0]   acc;
  logic [CW-1:0]  count;
  logic [N-1:0]   acc_sum;

  // Partial-product step: add the shifted multiplicand when the current
  // multiplier bit is set. The sum is naturally truncated to N bits.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // The zero flag follows the registered result, so it moves only when
  // result does.
  assign zero = (result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end
        end

        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // Last of the N steps: publish the completed sum directly so the
          // result is available in the DONE cycle.
          if (count == LAST) begin
            result <= acc_sum;
            state  <= DONE;
            done   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
